// File: rtl/ppu_cmd_receiver.sv
// Assembles pairs of 32-bit processor sends into 64-bit PPU commands and queues them in a circular FIFO.
// Optional PPU_RX_STATS_EN adds a wrapping 16-bit count of commands delivered to the PPU.
module ppu_cmd_receiver #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ppu_send,
   input  logic [31:0] send_data,
   output logic        proc_stall,
   output logic        cmd_valid,
   output logic [63:0] cmd_data,
   input  logic        cmd_ready,
   output logic        half_cmd,
   output logic        ovf_err,
   input  logic        clr_err,
   output logic [15:0] cmd_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   typedef enum logic {
      WAIT_LO = 1'b0,
      WAIT_HI = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [31:0]     r_loReg;
   logic [63:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_rdPtr;
   logic [AW-1:0]   r_wrPtr;
   logic [AW:0]     r_count;
   logic            r_ovfErr;
   logic            w_stall;
   logic            w_accept;
   logic            w_push;
   logic            w_pop;

   // Only the hi word can complete a command, so only it is ever held off.
   assign w_stall  = (r_count == C_FULL) && (r_state == WAIT_HI);
   assign w_accept = ppu_send && !w_stall;
   assign w_push   = w_accept && (r_state == WAIT_HI);
   assign w_pop    = (r_count != '0) && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_LO;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         WAIT_LO: if (w_accept) w_nextState = WAIT_HI;
         WAIT_HI: if (w_accept) w_nextState = WAIT_LO;
         default: w_nextState = WAIT_LO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_loReg <= '0;
      end else if (w_accept && (r_state == WAIT_LO)) begin
         r_loReg <= send_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= {send_data, r_loReg};
   end

   // A drop in the same cycle as a clear wins, so no overflow is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovfErr <= 1'b0;
      end else if (ppu_send && w_stall) begin
         r_ovfErr <= 1'b1;
      end else if (clr_err) begin
         r_ovfErr <= 1'b0;
      end
   end

`ifdef PPU_RX_STATS_EN
   logic [15:0] r_cmdCount;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmdCount <= '0;
      end else if (w_pop) begin
         r_cmdCount <= r_cmdCount + 16'd1;
      end
   end

   assign cmd_count = r_cmdCount;
`else
   assign cmd_count = 16'h0000;
`endif

   assign proc_stall = w_stall;
   assign cmd_valid  = (r_count != '0);
   assign cmd_data   = r_mem[r_rdPtr];
   assign half_cmd   = (r_state == WAIT_HI);
   assign ovf_err    = r_ovfErr;

endmodule
